sram_fetch_arbiter: RTL and testbench

SRAM_FETCH_ARBITER -- requirements
Module: sram_fetch_arbiter

---
 rtl/sram_arb_pkg.sv | 17 +
 rtl/sram_fetch_arbiter.sv | 132 +++++++++++++
 tb/tb_sram_fetch_arbiter.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arb_pkg.sv
// Shared types and widths for the SRAM fetch arbiter.
// Build macro SRAM_ARB_STATS_EN enables the loader stall counter.
package sram_arb_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 16;

  localparam logic [DATA_W-1:0] DEFAULT_TRANSPARENT_KEY = 16'hF81F;

  typedef enum logic [1:0] {
    IDLE,
    FETCH_SPR,
    FETCH_BG,
    LOAD
  } arb_state_e;

endpackage

// File: rtl/sram_fetch_arbiter.sv
// Shares one async SRAM between pixel fetches (sprite + background) and a loader.
// Build macro SRAM_ARB_STATS_EN adds a saturating loader stall counter.
module sram_fetch_arbiter
  import sram_arb_pkg::*;
#(
  parameter logic [DATA_W-1:0] TRANSPARENT_KEY = DEFAULT_TRANSPARENT_KEY
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              pix_strobe,
  input  logic              vga_blank,
  input  logic              sprite_hit,
  input  logic [ADDR_W-1:0] SPRITE_ADDR,
  input  logic [ADDR_W-1:0] background_ADDR,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ack,
  output logic [ADDR_W-1:0] SRAM_ADDR,
  output logic [DATA_W-1:0] SRAM_DQ_out,
  input  logic [DATA_W-1:0] SRAM_DQ_in,
  output logic              SRAM_OE_N,
  output logic              SRAM_WE_N,
  output logic [DATA_W-1:0] pixel_color,
  output logic              pixel_valid,
  output logic [15:0]       ld_wait_cnt
);

  arb_state_e        r_state;
  arb_state_e        w_next;
  logic [DATA_W-1:0] r_spr_word;
  logic              r_spr_hit;
  logic [DATA_W-1:0] r_pix;
  logic              r_valid;
  logic              w_slot;
  logic              w_load;
  logic              w_opaque;
  logic [DATA_W-1:0] w_pix;

  assign w_slot   = pix_strobe & ~vga_blank;
  assign w_load   = vga_blank & ld_req;
  assign w_opaque = r_spr_hit & (r_spr_word != TRANSPARENT_KEY);
  assign w_pix    = w_opaque ? r_spr_word : SRAM_DQ_in;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_slot)
          w_next = FETCH_SPR;
        else if (w_load)
          w_next = LOAD;
      end
      FETCH_SPR: w_next = FETCH_BG;
      FETCH_BG:  w_next = w_slot ? FETCH_SPR : IDLE;
      LOAD: begin
        if (w_slot)
          w_next = FETCH_SPR;
        else if (w_load & ~pix_strobe)
          w_next = LOAD;
        else
          w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Loader protocol holds each word until acked, so a trailing LOAD
  // cycle with ld_req low must not write.
  always_comb begin
    SRAM_ADDR   = '0;
    SRAM_DQ_out = '0;
    SRAM_OE_N   = 1'b1;
    SRAM_WE_N   = 1'b1;
    ld_ack      = 1'b0;
    unique case (1'b1)
      (r_state == FETCH_SPR): begin
        SRAM_ADDR = sprite_hit ? SPRITE_ADDR : background_ADDR;
        SRAM_OE_N = 1'b0;
      end
      (r_state == FETCH_BG): begin
        SRAM_ADDR = background_ADDR;
        SRAM_OE_N = 1'b0;
      end
      (r_state == LOAD && ld_req): begin
        SRAM_ADDR   = ld_addr;
        SRAM_DQ_out = ld_data;
        SRAM_WE_N   = 1'b0;
        ld_ack      = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state    <= IDLE;
      r_spr_word <= '0;
      r_spr_hit  <= 1'b0;
      r_pix      <= '0;
      r_valid    <= 1'b0;
    end else begin
      r_state <= w_next;
      r_valid <= (r_state == FETCH_BG);
      if (r_state == FETCH_SPR) begin
        r_spr_word <= SRAM_DQ_in;
        r_spr_hit  <= sprite_hit;
      end
      if (r_state == FETCH_BG)
        r_pix <= w_pix;
    end
  end

  assign pixel_color = r_pix;
  assign pixel_valid = r_valid;

`ifdef SRAM_ARB_STATS_EN
  logic [15:0] r_wait;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)
      r_wait <= '0;
    else if (ld_req && !ld_ack && r_wait != 16'hFFFF)
      r_wait <= r_wait + 16'd1;
  end

  assign ld_wait_cnt = r_wait;
`else
  assign ld_wait_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sram_fetch_arbiter.sv
// Self-checking bench for sram_fetch_arbiter with an async SRAM model.
// Honours SRAM_ARB_STATS_EN for the expected stall count.
module tb_sram_fetch_arbiter;

  localparam logic [15:0] KEY = 16'hF81F;
`ifdef SRAM_ARB_STATS_EN
  localparam int EXPW = 10;
`else
  localparam int EXPW = 0;
`endif

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        pix_strobe, vga_blank, sprite_hit;
  logic [19:0] SPRITE_ADDR, background_ADDR;
  logic        ld_req;
  logic [19:0] ld_addr;
  logic [15:0] ld_data;
  logic        ld_ack;
  logic [19:0] SRAM_ADDR;
  logic [15:0] SRAM_DQ_out, SRAM_DQ_in;
  logic        SRAM_OE_N, SRAM_WE_N;
  logic [15:0] pixel_color;
  logic        pixel_valid;
  logic [15:0] ld_wait_cnt;

  int total = 0;
  int bad = 0;

  logic [15:0] img [0:1023];
  logic [15:0] wm  [0:1023];
  logic        wv  [0:1023] = '{default: 1'b0};

  always #5 Clk = ~Clk;

  sram_fetch_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .pix_strobe(pix_strobe), .vga_blank(vga_blank),
    .sprite_hit(sprite_hit),
    .SPRITE_ADDR(SPRITE_ADDR), .background_ADDR(background_ADDR),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data),
    .ld_ack(ld_ack),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ_out(SRAM_DQ_out),
    .SRAM_DQ_in(SRAM_DQ_in),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
    .pixel_color(pixel_color), .pixel_valid(pixel_valid),
    .ld_wait_cnt(ld_wait_cnt)
  );

  // Async SRAM: reads are combinational, writes land on the clock edge.
  assign SRAM_DQ_in = wv[SRAM_ADDR[9:0]] ? wm[SRAM_ADDR[9:0]]
                                         : img[SRAM_ADDR[9:0]];

  always @(posedge Clk) begin
    if (!SRAM_WE_N) begin
      wm[SRAM_ADDR[9:0]] <= SRAM_DQ_out;
      wv[SRAM_ADDR[9:0]] <= 1'b1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] a,
                     input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, a, e);
    end
  endtask

  always @(negedge Clk) begin
    total++;
    if (!SRAM_OE_N && !SRAM_WE_N) begin
      bad++;
      $display("FAIL oe_we_both_low actual=00 required=not00");
    end
  end

  function automatic logic [15:0] pix_model(input logic hit,
      input logic [15:0] sw, input logic [15:0] bw);
    return (hit && sw != KEY) ? sw : bw;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_color"}, 32'(pixel_color), 32'h0);
    chk({tag, "_valid"}, 32'(pixel_valid), 32'h0);
    chk({tag, "_ack"},   32'(ld_ack), 32'h0);
    chk({tag, "_wait"},  32'(ld_wait_cnt), 32'h0);
    chk({tag, "_oe"},    32'(SRAM_OE_N), 32'h1);
    chk({tag, "_we"},    32'(SRAM_WE_N), 32'h1);
    chk({tag, "_addr"},  32'(SRAM_ADDR), 32'h0);
    chk({tag, "_dq"},    32'(SRAM_DQ_out), 32'h0);
  endtask

  typedef struct {
    logic        hit;
    logic [19:0] sa;
    logic [19:0] ba;
    logic [15:0] sw;
    logic [15:0] bw;
    logic [15:0] ec;
  } vec_t;

  vec_t v [6];

  initial begin
    int idx;
    int acks;
    int qd[$];
    logic [15:0] qc[$];
    logic pend;
    logic ev;

    v[0] = '{1'b1, 20'd100, 20'd200, 16'h1234, 16'h0000, 16'h1234};
    v[1] = '{1'b1, 20'd101, 20'd201, 16'hF81F, 16'h07E0, 16'h07E0};
    v[2] = '{1'b0, 20'd102, 20'd640, 16'h5555, 16'hABCD, 16'hABCD};
    v[3] = '{1'b1, 20'd103, 20'd202, 16'h0000, 16'hFFFF, 16'h0000};
    v[4] = '{1'b0, 20'd104, 20'd203, 16'hF81F, 16'hF81F, 16'hF81F};
    v[5] = '{1'b1, 20'd105, 20'd204, 16'hF81E, 16'h1111, 16'hF81E};

    pix_strobe = 0; vga_blank = 0; sprite_hit = 0;
    SPRITE_ADDR = '0; background_ADDR = '0;
    ld_req = 0; ld_addr = '0; ld_data = '0;

    repeat (2) @(posedge Clk);
    #1;
    chk_idle("reset");
    Reset = 1;

    for (int i = 0; i < 6; i++) begin
      img[v[i].sa[9:0]] = v[i].sw;
      img[v[i].ba[9:0]] = v[i].bw;
      @(posedge Clk); #1;
      pix_strobe = 1; vga_blank = 0;
      @(posedge Clk); #1;
      pix_strobe = 0;
      sprite_hit = v[i].hit;
      SPRITE_ADDR = v[i].sa;
      background_ADDR = v[i].ba;
      @(negedge Clk);
      chk("spr_addr", 32'(SRAM_ADDR),
          32'(v[i].hit ? v[i].sa : v[i].ba));
      chk("spr_oe", 32'(SRAM_OE_N), 32'h0);
      chk("spr_valid", 32'(pixel_valid), 32'h0);
      @(negedge Clk);
      chk("bg_addr", 32'(SRAM_ADDR), 32'(v[i].ba));
      chk("bg_oe", 32'(SRAM_OE_N), 32'h0);
      @(negedge Clk);
      chk("pix_valid", 32'(pixel_valid), 32'h1);
      chk("pix_color", 32'(pixel_color), 32'(v[i].ec));
      @(negedge Clk);
      chk("pix_valid_drop", 32'(pixel_valid), 32'h0);
    end

    // Loader burst during blanking; loader advances after each ack.
    vga_blank = 1; idx = 0; acks = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge Clk); #1;
      ld_req = (idx < 4);
      ld_addr = 20'(idx);
      ld_data = 16'(16'hA0 + idx);
      @(negedge Clk);
      if (ld_ack) begin
        acks++;
        chk("ld_addr", 32'(SRAM_ADDR), 32'(idx));
        chk("ld_we", 32'(SRAM_WE_N), 32'h0);
        chk("ld_oe", 32'(SRAM_OE_N), 32'h1);
        idx++;
      end
    end
    ld_req = 0;
    chk("ld_acks", 32'(acks), 32'd4);
    for (int k = 0; k < 4; k++) begin
      chk("ld_mem_valid", 32'(wv[k]), 32'h1);
      chk("ld_mem", 32'(wm[k]), 32'(16'hA0 + k));
    end

    // Loader request during active video must wait for blanking.
    @(posedge Clk); #1;
    Reset = 0;
    @(posedge Clk); #1;
    Reset = 1;
    vga_blank = 0; ld_req = 1; ld_addr = 20'd5; ld_data = 16'hBEEF;
    for (int c = 0; c < 10; c++) begin
      @(negedge Clk);
      chk("active_ack", 32'(ld_ack), 32'h0);
      chk("active_we", 32'(SRAM_WE_N), 32'h1);
      @(posedge Clk); #1;
    end
    vga_blank = 1;
    @(negedge Clk);
    chk("wait_cnt", 32'(ld_wait_cnt), 32'(EXPW));
    chk("blank_idle_ack", 32'(ld_ack), 32'h0);
    @(posedge Clk); #1;
    @(negedge Clk);
    chk("blank_ack", 32'(ld_ack), 32'h1);
    chk("blank_we", 32'(SRAM_WE_N), 32'h0);
    @(posedge Clk); #1;
    ld_req = 0;
    chk("held_mem", 32'(wm[5]), 32'hBEEF);

    // Reset asserted in the middle of a write cycle.
    @(posedge Clk); #1;
    ld_req = 1; ld_addr = 20'd6; ld_data = 16'h1111;
    @(posedge Clk); #1;
    chk("mid_we", 32'(SRAM_WE_N), 32'h0);
    #2;
    Reset = 0;
    #1;
    chk_idle("rst_load");
    @(posedge Clk); #1;
    ld_req = 0;
    chk("rst_no_write", 32'(wv[6]), 32'h0);
    Reset = 1; vga_blank = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge Clk);
      chk("post_rst_valid", 32'(pixel_valid), 32'h0);
    end

    // Random pixel stream: strobe every 2 Clk, random blanking.
    for (int a = 256; a < 384; a++)
      img[a] = ($urandom_range(3) == 0) ? KEY : 16'($urandom);
    pend = 0;
    for (int c = 0; c < 406; c++) begin
      @(posedge Clk); #1;
      if (c % 2 == 0) begin
        pix_strobe = (c < 400);
        vga_blank = ($urandom_range(4) == 0);
        pend = pix_strobe & !vga_blank;
      end else begin
        pix_strobe = 0;
        sprite_hit = 1'($urandom_range(1));
        SPRITE_ADDR = 20'(256 + $urandom_range(63));
        background_ADDR = 20'(320 + $urandom_range(63));
        if (pend) begin
          qd.push_back(c + 2);
          qc.push_back(pix_model(sprite_hit, img[SPRITE_ADDR[9:0]],
                                 img[background_ADDR[9:0]]));
          pend = 0;
        end
      end
      @(negedge Clk);
      ev = (qd.size() > 0) && (qd[0] == c);
      chk("rnd_valid", 32'(pixel_valid), 32'(ev));
      if (ev) begin
        chk("rnd_color", 32'(pixel_color), 32'(qc[0]));
        void'(qd.pop_front());
        void'(qc.pop_front());
      end
    end
    chk("rnd_drain", 32'(qd.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
